mem_access_stage: RTL

- MEM stage of the MIPS datapath, directly downstream of the EX-stage ALU.
- Takes the ALU result as the effective address, plus the store data and control, and runs a multi-cycle request/grant/response transaction on a synchronous data-memory port.
- Performs byte-lane steering, load alignment and sign/zero extension, and hands one registered result per operation to write-back.
- Non-memory ops pass the ALU result straight through with 1-cycle latency.

---
 rtl/mem_stage_pkg.sv | 40 ++++
 rtl/load_align.sv | 28 ++
 rtl/mem_access_stage.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MEM pipeline stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    MemByte = 2'b00,
    MemHalf = 2'b01,
    MemWord = 2'b10,
    MemIll  = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StWait = 2'b10
  } state_t;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

  // Byte enables for an access of the given size at the given byte offset.
  function automatic logic [3:0] byte_enables(mem_size_t size, logic [1:0] offset);
    case (size)
      MemByte: byte_enables = 4'b0001 << offset;
      MemHalf: byte_enables = 4'b0011 << {offset[1], 1'b0};
      default: byte_enables = 4'b1111;
    endcase
  endfunction

  // Replicate store data across all lanes so the byte enables pick the right one.
  function automatic logic [31:0] lane_replicate(mem_size_t size, logic [31:0] data);
    case (size)
      MemByte: lane_replicate = {4{data[7:0]}};
      MemHalf: lane_replicate = {2{data[15:0]}};
      default: lane_replicate = data;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half lane from a read word and sign/zero extends it.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  mem_size_t   size,
  input  logic        is_unsigned,
  output logic [31:0] value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[{addr, 3'b000} +: 8];
  assign half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

  // Select lane by access size and extend.
  always_comb begin
    value = rdata;
    case (size)
      MemByte: value = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
      MemHalf: value = {{16{~is_unsigned & half_lane[15]}}, half_lane};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: runs req/gnt/rvalid transactions on the data-memory port and
// hands one registered result per operation to write-back.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] alu_out,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  output logic        wb_valid,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        exc,
  output logic [1:0]  exc_cause,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [29:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wb_valid_q, wb_valid_d;
  logic [31:0]     wb_result_q, wb_result_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_reg_write_q, wb_reg_write_d;
  logic            exc_q, exc_d;
  logic [1:0]      exc_cause_q, exc_cause_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [29:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            op_reg_write_q, op_reg_write_d;
  mem_size_t       op_size_q, op_size_d;
  logic            op_unsigned_q, op_unsigned_d;
  logic [1:0]      op_lo_q, op_lo_d;

  mem_size_t   size_in;
  logic        is_mem, illegal, misaligned, expire;
  logic [31:0] load_value;

  assign size_in    = mem_size_t'(mem_size);
  assign is_mem     = mem_read | mem_write;
  assign illegal    = is_mem && ((mem_read && mem_write) || size_in == MemIll);
  assign misaligned = is_mem && ((size_in == MemHalf && alu_out[0]) ||
                                 (size_in == MemWord && alu_out[1:0] != 2'b00));
  // Current cycle is the TIMEOUT_CYC-th cycle spent in REQ/WAIT.
  assign expire     = (cnt_q == CntW'(TIMEOUT_CYC - 1));

  load_align u_load_align (
    .rdata       (dmem_rdata),
    .addr        (op_lo_q),
    .size        (op_size_q),
    .is_unsigned (op_unsigned_q),
    .value       (load_value)
  );

  // Next-state, bus and write-back decisions.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    wb_valid_d     = 1'b0;
    wb_result_d    = wb_result_q;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = wb_reg_write_q;
    exc_d          = 1'b0;
    exc_cause_d    = EXC_NONE;
    req_d          = req_q;
    we_d           = we_q;
    be_d           = be_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    op_reg_write_d = op_reg_write_q;
    op_size_d      = op_size_q;
    op_unsigned_d  = op_unsigned_q;
    op_lo_d        = op_lo_q;

    unique case (state_q)
      StIdle: begin
        if (ex_valid) begin
          wb_rd_d     = rd;
          wb_result_d = alu_out;
          if (illegal) begin
            wb_valid_d     = 1'b1;
            exc_d          = 1'b1;
            exc_cause_d    = EXC_ILLEGAL;
            wb_reg_write_d = 1'b0;
          end else if (misaligned) begin
            wb_valid_d     = 1'b1;
            exc_d          = 1'b1;
            exc_cause_d    = EXC_MISALIGN;
            wb_reg_write_d = 1'b0;
          end else if (!is_mem) begin
            wb_valid_d     = 1'b1;
            wb_reg_write_d = reg_write;
          end else begin
            state_d        = StReq;
            cnt_d          = '0;
            req_d          = 1'b1;
            we_d           = mem_write;
            be_d           = byte_enables(size_in, alu_out[1:0]);
            addr_d         = alu_out[31:2];
            wdata_d        = lane_replicate(size_in, wdata);
            op_reg_write_d = reg_write;
            op_size_d      = size_in;
            op_unsigned_d  = mem_unsigned;
            op_lo_d        = alu_out[1:0];
          end
        end
      end
      StReq: begin
        cnt_d = cnt_q + 1'b1;
        // A grant in the expiry cycle still completes normally.
        if (dmem_gnt) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d        = StIdle;
            wb_valid_d     = 1'b1;
            wb_reg_write_d = 1'b0;
          end else begin
            state_d = StWait;
          end
        end else if (expire) begin
          req_d          = 1'b0;
          state_d        = StIdle;
          wb_valid_d     = 1'b1;
          exc_d          = 1'b1;
          exc_cause_d    = EXC_TIMEOUT;
          wb_reg_write_d = 1'b0;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (dmem_rvalid) begin
          state_d        = StIdle;
          wb_valid_d     = 1'b1;
          wb_result_d    = load_value;
          wb_reg_write_d = op_reg_write_q;
        end else if (expire) begin
          state_d        = StIdle;
          wb_valid_d     = 1'b1;
          exc_d          = 1'b1;
          exc_cause_d    = EXC_TIMEOUT;
          wb_reg_write_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      wb_valid_q     <= 1'b0;
      wb_result_q    <= '0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      exc_q          <= 1'b0;
      exc_cause_q    <= EXC_NONE;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      be_q           <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      op_reg_write_q <= 1'b0;
      op_size_q      <= MemByte;
      op_unsigned_q  <= 1'b0;
      op_lo_q        <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wb_valid_q     <= wb_valid_d;
      wb_result_q    <= wb_result_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      exc_q          <= exc_d;
      exc_cause_q    <= exc_cause_d;
      req_q          <= req_d;
      we_q           <= we_d;
      be_q           <= be_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      op_reg_write_q <= op_reg_write_d;
      op_size_q      <= op_size_d;
      op_unsigned_q  <= op_unsigned_d;
      op_lo_q        <= op_lo_d;
    end
  end

  assign ex_ready     = (state_q == StIdle);
  assign wb_valid     = wb_valid_q;
  assign wb_result    = wb_result_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_reg_write_q;
  assign exc          = exc_q;
  assign exc_cause    = exc_cause_q;
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_be      = be_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;

endmodule
